// File: rtl/rr_arb4_src.sv
// rr_arb4_src: four-channel round-robin source arbiter feeding the 16-bit 4:1 selector mux.
// One word per cycle is granted in rotating-priority order and held in a single-entry
// valid/ready output register. The granted channel index is registered as sel_o so the
// downstream mux always matches the held word.
// Optional feature: define ARB_STATS_EN to add per-channel saturating grant counters
// (stats_clr_i, grant_cnt0_o..grant_cnt3_o).

module rr_arb4_src #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       in_valid_i,
    input  logic [WIDTH-1:0] in_data0_i,
    input  logic [WIDTH-1:0] in_data1_i,
    input  logic [WIDTH-1:0] in_data2_i,
    input  logic [WIDTH-1:0] in_data3_i,
    output logic [3:0]       in_ready_o,
    output logic [1:0]       sel_o,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
`ifdef ARB_STATS_EN
    ,
    input  logic             stats_clr_i,
    output logic [7:0]       grant_cnt0_o,
    output logic [7:0]       grant_cnt1_o,
    output logic [7:0]       grant_cnt2_o,
    output logic [7:0]       grant_cnt3_o
`endif
);

    logic [1:0]       last_q, last_d;
    logic [1:0]       sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             free;
    logic             any_valid;
    logic             accept;
    logic [1:0]       winner;
    logic [WIDTH-1:0] win_data;

    assign free      = !out_valid_q || out_ready_i;
    assign any_valid = |in_valid_i;
    assign accept    = free && any_valid;

    // Rotating-priority search starting one past the last granted channel.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        winner = last_q;
        found  = 1'b0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!found && in_valid_i[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Payload of the winning channel.
    always_comb begin
        win_data = in_data0_i;
        case (winner)
            2'd0: win_data = in_data0_i;
            2'd1: win_data = in_data1_i;
            2'd2: win_data = in_data2_i;
            2'd3: win_data = in_data3_i;
            default: win_data = in_data0_i;
        endcase
    end

    // One-hot accept back to the winning requester; zero while the output stage is full.
    always_comb begin
        in_ready_o = 4'b0000;
        if (accept) begin
            in_ready_o[winner] = 1'b1;
        end
    end

    // Next state of the output stage: an accept overwrites, a lone transfer empties.
    always_comb begin
        last_d      = last_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept) begin
            last_d      = winner;
            sel_d       = winner;
            out_valid_d = 1'b1;
            out_data_d  = win_data;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register stage and priority pointer.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            last_q      <= 2'd3;
            sel_q       <= 2'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            last_q      <= last_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign sel_o       = sel_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;

`ifdef ARB_STATS_EN
    logic [7:0] grant_cnt_q [4];

    // Saturating per-channel accept counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 4; k++) begin
                grant_cnt_q[k] <= 8'd0;
            end
        end else if (stats_clr_i) begin
            for (int k = 0; k < 4; k++) begin
                grant_cnt_q[k] <= 8'd0;
            end
        end else if (accept && (grant_cnt_q[winner] != 8'hFF)) begin
            grant_cnt_q[winner] <= grant_cnt_q[winner] + 8'd1;
        end
    end

    assign grant_cnt0_o = grant_cnt_q[0];
    assign grant_cnt1_o = grant_cnt_q[1];
    assign grant_cnt2_o = grant_cnt_q[2];
    assign grant_cnt3_o = grant_cnt_q[3];
`endif

endmodule
